pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline controller for the 5-stage core. It is the driver side of every stage register's `wren`: it decides each cycle which of PC, FD, DE, EM and MW advance, hold or take a bubble. It resolves load-use hazards, branch/jump redirects from MEM, and instruction- and data-memory wait states. It also keeps saturating stall and flush counters for debug.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID (FD output).
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction reads rs / rt.
- `de_mem_read` in 1: the EX-stage instruction is a load.
- `de_dst_reg` in 5: destination register of that load.
- `em_mem_access` in 1: the MEM-stage instruction reads or writes data memory.
- `em_redirect` in 1: MEM-stage branch taken or jump (`(dec_branch & alu_result_zero) | dec_jmp`).
- `imem_ready` in 1: instruction word at the current PC is valid this cycle.
- `dmem_ready` in 1: data memory completes the request this cycle.
- `dmem_req` out 1: data memory request, held until `dmem_ready`.
- `pc_wren`, `fd_wren`, `de_wren`, `em_wren`, `mw_wren` out 1: stage enables.
- `pc_sel_branch` out 1: PC input selects EM `branch_pc` instead of next_pc.
- `fd_flush`, `de_flush`, `em_flush` out 1: the stage register loads zeros (NOP bubble) on this write; only meaningful with the matching `wren`=1.
- `stall_cnt`, `flush_cnt` out `CNT_W`: saturating counters.

## Operation
- FSM states:
  - RUN: `dmem_req` = `em_mem_access`. If `em_mem_access` & !`dmem_ready`, go to DMEM_WAIT.
  - DMEM_WAIT: `dmem_req`=1. Return to RUN on `dmem_ready`.
- Freeze (`frozen`) = `em_mem_access` & !`dmem_ready`, in either state.
  - All five `wren`=0. All flush=0. `stall_cnt`+1.
  - Freeze overrides every other condition.
- When not frozen, the default is all `wren`=1 and all flush=0. Overrides apply in priority order, highest first:
  1. Redirect (`em_redirect`): `pc_sel_branch`=1, `fd_flush`=`de_flush`=`em_flush`=1. `flush_cnt`+1. Load-use and imem conditions are ignored this cycle.
  2. Load-use: `de_mem_read` & `de_dst_reg`≠0 & ((`id_uses_rs` & `id_rs`==`de_dst_reg`) | (`id_uses_rt` & `id_rt`==`de_dst_reg`)).
     - `pc_wren`=`fd_wren`=0, `de_flush`=1.
     - EM and MW advance. `stall_cnt`+1.
  3. Imem not ready (!`imem_ready`): `pc_wren`=0, `fd_flush`=1, downstream advances. `stall_cnt`+1.
- Load-use and imem stall in the same cycle: load-use rules apply (`fd_wren`=0 keeps the ID instruction). The stall is counted once.
- Counters saturate at all-ones. There is no wrap.
- Enables and flushes are combinational from the inputs and state. Only the FSM state and the counters are registered.

## Timing
- During reset (`reset_n`=0 at an edge, and the cycle it is sampled):
  - All `wren`=0, all flushes=0, `pc_sel_branch`=0, `dmem_req`=0.
  - After the edge: state=RUN, both counters=0.
- Zero-wait data memory (`dmem_ready` in the same cycle as the request): no stall, stays in RUN.
- N wait cycles: exactly N frozen cycles. The pipeline advances on the `dmem_ready` cycle.
- Load-use: exactly one bubble. The cycle after, the load is in MEM and no hazard remains.
- Redirect: the PC holds the target after the edge. Three bubbles enter FD/DE/EM; MW takes the branch.
- Reset mid-DMEM_WAIT: the FSM returns to RUN and `dmem_req` drops in the reset cycle.

## Structure
- Shared package `kanade_pkg`: FSM state enum `ctrl_state_t` {RUN, DMEM_WAIT} and constant `REG_ZERO`=5'd0.
- One sub-module, `sat_counter` (parameter `W`; inputs `inc`, `clr`), instantiated twice.
- The hazard/priority logic is a single `always_comb`.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `em_redirect`=1 -> all outputs 0, counters 0; after release, all `wren`=1.
- Load-use: `de_mem_read`=1, `de_dst_reg`=5, `id_rs`=5, `id_uses_rs`=1 -> `pc_wren`=`fd_wren`=0, `de_flush`=1, EM/MW=1, `stall_cnt`=1. Same stimulus with `de_dst_reg`=0 -> no stall.
- Redirect concurrent with load-use and `imem_ready`=0 -> `pc_sel_branch`=1, three flushes, all `wren`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- Dmem wait: `em_mem_access`=1, `dmem_ready` low for 3 cycles -> 3 frozen cycles, state DMEM_WAIT, `dmem_req` high for 4 cycles, `stall_cnt`=3.
- Reset asserted during the second wait cycle -> state RUN, `dmem_req`=0, `stall_cnt`=0.
- Saturation: `CNT_W`=4, 20 imem stalls -> `stall_cnt`=15 holds.

Source files
------------

// File: rtl/kanade_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// the hard-wired zero register index.
package kanade_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Clear has priority; increment stops once every bit is set.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: drives the stage-register enables and bubble
// flushes for PC/FD/DE/EM/MW, resolving dmem waits, MEM-stage redirects,
// load-use hazards and imem wait states, and keeps debug stall/flush counts.
module pipeline_ctrl
    import kanade_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             de_mem_read,
    input  logic [4:0]       de_dst_reg,
    input  logic             em_mem_access,
    input  logic             em_redirect,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_wren,
    output logic             fd_wren,
    output logic             de_wren,
    output logic             em_wren,
    output logic             mw_wren,
    output logic             pc_sel_branch,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t r_state;
    logic        w_frozen;
    logic        w_load_use;
    logic        w_stall_inc;
    logic        w_flush_inc;

    // Data-memory handshake FSM: stay in DMEM_WAIT until the access completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:       if (em_mem_access && !dmem_ready) r_state <= DMEM_WAIT;
                DMEM_WAIT: if (dmem_ready) r_state <= RUN;
                default:   r_state <= RUN;
            endcase
        end
    end

    // Hazard priority: freeze > redirect > load-use > imem wait; reset forces all low.
    always_comb begin
        dmem_req      = 1'b0;
        pc_wren       = 1'b0;
        fd_wren       = 1'b0;
        de_wren       = 1'b0;
        em_wren       = 1'b0;
        mw_wren       = 1'b0;
        pc_sel_branch = 1'b0;
        fd_flush      = 1'b0;
        de_flush      = 1'b0;
        em_flush      = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        w_frozen   = em_mem_access && !dmem_ready;
        w_load_use = de_mem_read && (de_dst_reg != REG_ZERO) &&
                     ((id_uses_rs && (id_rs == de_dst_reg)) ||
                      (id_uses_rt && (id_rt == de_dst_reg)));

        if (reset_n) begin
            dmem_req = (r_state == DMEM_WAIT) || em_mem_access;
            if (w_frozen) begin
                w_stall_inc = 1'b1;
            end else begin
                pc_wren = 1'b1;
                fd_wren = 1'b1;
                de_wren = 1'b1;
                em_wren = 1'b1;
                mw_wren = 1'b1;
                if (em_redirect) begin
                    pc_sel_branch = 1'b1;
                    fd_flush      = 1'b1;
                    de_flush      = 1'b1;
                    em_flush      = 1'b1;
                    w_flush_inc   = 1'b1;
                end else if (w_load_use) begin
                    // fd_wren=0 also covers a coincident imem wait: ID is kept as-is.
                    pc_wren     = 1'b0;
                    fd_wren     = 1'b0;
                    de_flush    = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (!imem_ready) begin
                    pc_wren     = 1'b0;
                    fd_flush    = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (w_stall_inc),
        .clr   (!reset_n),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .inc   (w_flush_inc),
        .clr   (!reset_n),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, scoreboarded bench for pipeline_ctrl: expected outputs are pushed
// when inputs are driven and popped when the outputs are sampled.
module tb_pipeline_ctrl;
    import kanade_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt, de_dst_reg;
    logic        id_uses_rs, id_uses_rt, de_mem_read;
    logic        em_mem_access, em_redirect, imem_ready, dmem_ready;

    logic        dmem_req, pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        pc_sel_branch, fd_flush, de_flush, em_flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_dmem_req, s_pc_wren, s_fd_wren, s_de_wren, s_em_wren, s_mw_wren;
    logic        s_pc_sel_branch, s_fd_flush, s_de_flush, s_em_flush;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [9:0]  sb_q[$];

    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    int unsigned m_sat4  = 0;
    bit          m_wait  = 1'b0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
        .em_mem_access(em_mem_access), .em_redirect(em_redirect),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren),
        .em_wren(em_wren), .mw_wren(mw_wren), .pc_sel_branch(pc_sel_branch),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg),
        .em_mem_access(em_mem_access), .em_redirect(em_redirect),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dmem_req(s_dmem_req), .pc_wren(s_pc_wren), .fd_wren(s_fd_wren), .de_wren(s_de_wren),
        .em_wren(s_em_wren), .mw_wren(s_mw_wren), .pc_sel_branch(s_pc_sel_branch),
        .fd_flush(s_fd_flush), .de_flush(s_de_flush), .em_flush(s_em_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference output vector {req, pc, fd, de, em, mw, sel, fdf, def, emf}.
    function automatic logic [9:0] model_out();
        logic lu;
        if (!reset_n) return 10'b0;
        lu = de_mem_read && (de_dst_reg != 5'd0) &&
             ((id_uses_rs && id_rs == de_dst_reg) || (id_uses_rt && id_rt == de_dst_reg));
        if (em_mem_access && !dmem_ready) return 10'b1_00000_0_000;
        if (em_redirect)  return {m_wait | em_mem_access, 9'b11111_1_111};
        if (lu)           return {m_wait | em_mem_access, 9'b00111_0_010};
        if (!imem_ready)  return {m_wait | em_mem_access, 9'b01111_0_100};
        return {m_wait | em_mem_access, 9'b11111_0_000};
    endfunction

    task automatic model_edge();
        bit frz, lu, st_inc, fl_inc;
        if (!reset_n) begin
            m_wait = 1'b0; m_stall = 0; m_flush = 0; m_sat4 = 0;
        end else begin
            frz = em_mem_access && !dmem_ready;
            lu  = de_mem_read && (de_dst_reg != 5'd0) &&
                  ((id_uses_rs && id_rs == de_dst_reg) || (id_uses_rt && id_rt == de_dst_reg));
            st_inc = frz || (!em_redirect && (lu || !imem_ready));
            fl_inc = !frz && em_redirect;
            if (st_inc && m_stall < 65535) m_stall++;
            if (st_inc && m_sat4 < 15)     m_sat4++;
            if (fl_inc && m_flush < 65535) m_flush++;
            m_wait = m_wait ? !dmem_ready : frz;
        end
    endtask

    // One cycle: push expectation, sample outputs mid-cycle, then check registered state after the edge.
    task automatic cyc(input string tag);
        logic [9:0] exp_v;
        sb_q.push_back(model_out());
        #1;
        exp_v = sb_q.pop_front();
        chk({tag, ".out"}, 32'({dmem_req, pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                                pc_sel_branch, fd_flush, de_flush, em_flush}), 32'(exp_v));
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".stall"}, 32'(stall_cnt), m_stall);
        chk({tag, ".flush"}, 32'(flush_cnt), m_flush);
        chk({tag, ".sat4"},  32'(s_stall_cnt), m_sat4);
        chk({tag, ".state"}, 32'(dut.r_state), 32'(m_wait ? DMEM_WAIT : RUN));
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 0; id_uses_rt = 0;
        de_mem_read = 0; de_dst_reg = 5'd0;
        em_mem_access = 0; em_redirect = 0; imem_ready = 1; dmem_ready = 1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        @(negedge clk);

        // Reset with a pending redirect: everything low, counters cleared.
        em_redirect = 1;
        cyc("rst0");
        cyc("rst1");
        chk("rst.pc_wren", 32'(pc_wren), 0);
        reset_n = 1; em_redirect = 0;
        cyc("run");
        chk("run.mw_wren", 32'(mw_wren), 1);

        // Load-use through rs, then the same with the zero register as destination.
        de_mem_read = 1; de_dst_reg = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        cyc("lu_rs");
        chk("lu_rs.cnt", 32'(stall_cnt), 1);
        de_dst_reg = 5'd0; id_rs = 5'd0;
        cyc("lu_r0");
        // Load-use through rt only; then coincident imem stall counted once.
        id_uses_rs = 0; id_rs = 5'd7; de_dst_reg = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
        cyc("lu_rt");
        imem_ready = 0;
        cyc("lu_imem");
        de_mem_read = 0;
        cyc("imem");

        // Redirect dominates load-use and imem wait.
        de_mem_read = 1;
        em_redirect = 1;
        cyc("redir");
        chk("redir.fcnt", 32'(flush_cnt), 1);
        idle();

        // Zero-wait dmem access, then a 3-cycle wait.
        em_mem_access = 1; dmem_ready = 1;
        cyc("dm0");
        dmem_ready = 0;
        repeat (3) cyc("dmw");
        chk("dmw.state", 32'(dut.r_state), 32'(DMEM_WAIT));
        dmem_ready = 1; em_redirect = 1;
        cyc("dmdone");
        idle();
        cyc("dmidle");

        // Reset lands in the second wait cycle.
        em_mem_access = 1; dmem_ready = 0;
        cyc("dmw_a");
        reset_n = 0;
        cyc("dmw_rst");
        chk("dmw_rst.stall", 32'(stall_cnt), 0);
        reset_n = 1; idle();
        cyc("post_rst");

        // Saturation of the 4-bit instance under 20 imem stalls.
        imem_ready = 0;
        repeat (20) cyc("sat");
        chk("sat.hold", 32'(s_stall_cnt), 15);
        idle();
        cyc("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
